// File: rtl/sync_sampler_pkg.sv
// Shared sync sampler parameters and FSM encodings.
package sync_sampler_pkg;

   localparam int MSB_DEF     = 15;
   localparam int CNT_MSB_DEF = 15;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

endpackage

// File: rtl/sync_sampler_sat_sub.sv
// Combinational signed subtract y = sat(a - b), clamped to the
// two's complement range of MSB+1 bits.
module sat_sub
   import sync_sampler_pkg::*;
#(
   parameter int MSB = MSB_DEF
) (
   input  logic [MSB:0] a,
   input  logic [MSB:0] b,
   output logic [MSB:0] y
);

   localparam logic [MSB:0] MAXV = {1'b0, {MSB{1'b1}}};
   localparam logic [MSB:0] MINV = {1'b1, {MSB{1'b0}}};

   logic [MSB+1:0] diff;

   // one guard bit; top two bits disagreeing means overflow
   always_comb begin
      diff = {a[MSB], a} - {b[MSB], b};
      unique case (1'b1)
         (diff[MSB+1:MSB] == 2'b01): y = MAXV;
         (diff[MSB+1:MSB] == 2'b10): y = MINV;
         default:                    y = diff[MSB:0];
      endcase
   end

endmodule

// File: rtl/sync_sampler.sv
// Captures a configured number of samples after start, removing
// a latched offset from each with saturation.
module sync_sampler
   import sync_sampler_pkg::*;
#(
   parameter int MSB     = MSB_DEF,
   parameter int CNT_MSB = CNT_MSB_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [MSB:0]     sampler_reg_data_out0,
   input  logic [MSB:0]     sampler_reg_data_out1,
   input  logic             start,
   input  logic [MSB:0]     din,
   input  logic             din_valid,
   output logic [MSB:0]     dout,
   output logic             dout_valid,
   output logic [CNT_MSB:0] sample_cnt,
   output logic             busy,
   output logic             done
);

   state_t           state;
   logic [CNT_MSB:0] num;
   logic [CNT_MSB:0] num_in;
   logic [CNT_MSB:0] cnt_nxt;
   logic [MSB:0]     sub;
   logic [MSB:0]     diff;

   generate
      if (CNT_MSB > MSB) begin : g_ext
         assign num_in = {{(CNT_MSB-MSB){1'b0}}, sampler_reg_data_out0};
      end else begin : g_trunc
         assign num_in = sampler_reg_data_out0[CNT_MSB:0];
      end
   endgenerate

   assign cnt_nxt = sample_cnt + {{CNT_MSB{1'b0}}, 1'b1};

   sat_sub #(
      .MSB (MSB)
   ) u_sat (
      .a (din),
      .b (sub),
      .y (diff)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         num        <= '0;
         sub        <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
         sample_cnt <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         dout_valid <= 1'b0;
         done       <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  num        <= num_in;
                  sub        <= sampler_reg_data_out1;
                  sample_cnt <= '0;
                  if (num_in == '0) begin
                     state <= FIN;
                     done  <= 1'b1;
                  end else begin
                     state <= RUN;
                     busy  <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (din_valid) begin
                  dout       <= diff;
                  dout_valid <= 1'b1;
                  sample_cnt <= cnt_nxt;
                  // last sample: done lands with its dout_valid
                  if (cnt_nxt == num) begin
                     state <= FIN;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                  end
               end
            end
            FIN: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sync_sampler.sv
// Scoreboard bench for sync_sampler: directed vectors, expected
// responses queued at issue time and checked by a monitor.
module tb_sync_sampler;

   logic        clk;
   logic        rst_n;
   logic [15:0] reg0;
   logic [15:0] reg1;
   logic        start;
   logic [15:0] din;
   logic        din_valid;
   logic [15:0] dout;
   logic        dout_valid;
   logic [15:0] sample_cnt;
   logic        busy;
   logic        done;

   typedef struct {
      int          cyc;
      logic        valid;
      logic [15:0] dout;
      logic [15:0] cnt;
      logic        done;
   } exp_t;

   exp_t sbq[$];
   int   cyc = 0;
   int   passed = 0;
   int   total = 0;

   sync_sampler dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .sampler_reg_data_out0 (reg0),
      .sampler_reg_data_out1 (reg1),
      .start                 (start),
      .din                   (din),
      .din_valid             (din_valid),
      .dout                  (dout),
      .dout_valid            (dout_valid),
      .sample_cnt            (sample_cnt),
      .busy                  (busy),
      .done                  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(string nm, longint act, longint exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endfunction

   always @(negedge clk) begin
      if (rst_n && (dout_valid || done)) begin
         if (sbq.size() == 0) begin
            total++;
            $display("FAIL unexpected_out: got dout=%0d done=%0d expected none",
                     $signed(dout), done);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("sb_cycle", cyc, e.cyc);
            chk("sb_valid", dout_valid, e.valid);
            if (e.valid) chk("sb_dout", $signed(dout), $signed(e.dout));
            chk("sb_cnt", sample_cnt, e.cnt);
            chk("sb_done", done, e.done);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(logic v, int d, int c, logic dn);
      exp_t e;
      e.cyc   = cyc + 1;
      e.valid = v;
      e.dout  = d[15:0];
      e.cnt   = c[15:0];
      e.done  = dn;
      sbq.push_back(e);
   endtask

   task automatic do_start(int n, int s);
      reg0  = n[15:0];
      reg1  = s[15:0];
      start = 1'b1;
      if (n == 0) push(1'b0, 0, 0, 1'b1);
      tick();
      start = 1'b0;
   endtask

   task automatic send(int x, int e, int k, logic last);
      din       = x[15:0];
      din_valid = 1'b1;
      push(1'b1, e, k, last);
      tick();
      din_valid = 1'b0;
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      rst_n     = 1'b0;
      reg0      = '0;
      reg1      = '0;
      start     = 1'b0;
      din       = '0;
      din_valid = 1'b0;
      #12;
      chk("rst_dout", dout, 0);
      chk("rst_dvalid", dout_valid, 0);
      chk("rst_cnt", sample_cnt, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // basic pass-through, continuous valid
      do_start(4, 0);
      chk("t1_busy", busy, 1);
      send(10, 10, 1, 1'b0);
      send(20, 20, 2, 1'b0);
      send(30, 30, 3, 1'b0);
      send(40, 40, 4, 1'b1);
      chk("t1_busy_fin", busy, 0);
      idle(2);
      chk("t1_busy_after", busy, 0);
      chk("t1_cnt_hold", sample_cnt, 4);

      // offset with gaps
      do_start(3, 5);
      send(7, 2, 1, 1'b0);
      idle(1);
      send(-3, -8, 2, 1'b0);
      idle(1);
      send(100, 95, 3, 1'b1);
      idle(2);
      chk("t2_cnt_hold", sample_cnt, 3);

      // saturation, both rails
      do_start(1, -100);
      send(32700, 32767, 1, 1'b1);
      idle(2);
      do_start(1, 100);
      send(-32700, -32768, 1, 1'b1);
      idle(2);
      do_start(3, 1);
      send(-32767, -32768, 1, 1'b0);
      send(-32768, -32768, 2, 1'b0);
      send(32767, 32766, 3, 1'b1);
      idle(1);
      chk("t3_dout_hold", $signed(dout), 32766);
      idle(1);

      // zero count
      do_start(0, 0);
      chk("t4_done", done, 1);
      chk("t4_busy", busy, 0);
      chk("t4_dvalid", dout_valid, 0);
      tick();
      chk("t4_done_off", done, 0);
      chk("t4_busy2", busy, 0);
      idle(2);

      // config change and start during RUN, start in FIN
      do_start(2, 0);
      send(11, 11, 1, 1'b0);
      reg0  = 16'd9;
      reg1  = 16'd50;
      start = 1'b1;
      send(22, 22, 2, 1'b1);
      start = 1'b0;
      chk("t5_busy", busy, 0);
      reg0      = 16'd1;
      start     = 1'b1;
      din       = 16'd33;
      din_valid = 1'b1;
      tick();
      start     = 1'b0;
      din_valid = 1'b0;
      do_start(9, 1);
      chk("t5_busy_new", busy, 1);
      for (int i = 1; i <= 9; i++)
         send(10 * i, 10 * i - 1, i, (i == 9));
      idle(2);
      chk("t5_cnt_hold", sample_cnt, 9);

      // reset mid-capture
      do_start(5, 0);
      send(1, 1, 1, 1'b0);
      send(2, 2, 2, 1'b0);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("t6_dout", dout, 0);
      chk("t6_dvalid", dout_valid, 0);
      chk("t6_cnt", sample_cnt, 0);
      chk("t6_busy", busy, 0);
      chk("t6_done", done, 0);
      idle(2);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      do_start(1, 0);
      send(7, 7, 1, 1'b1);
      idle(3);
      chk("t6_cnt_after", sample_cnt, 1);
      chk("sb_empty", sbq.size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
